// File: rtl/fp_norm_round_pipe_pkg.sv
// Shared constants and width helpers for the normalise/round/pack pipe.
// Holds rounding-mode encodings, field-width function and clog2.
package fp_pipe_pkg;

    localparam int RND_HALF_UP      = 0;
    localparam int RND_NEAREST_EVEN = 1;

    // Input word: implicit bit + stored mantissa + guard/sticky bits.
    function automatic int in_width(input int man_w, input int rnd_w);
        return man_w + rnd_w + 1;
    endfunction

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int x = v - 1; x > 0; x = x >> 1)
            r++;
        return r;
    endfunction

endpackage

// File: rtl/fp_norm_round_pipe_if.sv
// Valid/ready bundle for the normalise/round/pack pipe.
// slave = the pipe itself, master = upstream/downstream driver.
interface fp_norm_round_pipe_if
    import fp_pipe_pkg::*;
#(
    parameter int MAN_W  = 23,
    parameter int EXP_W  = 8,
    parameter int RND_W  = 3,
    parameter int SIDE_W = 31
) ();

    localparam int W = in_width(MAN_W, RND_W);

    logic                   in_valid;
    logic                   in_ready;
    logic [W-1:0]           m_sub;
    logic [SIDE_W-1:0]      side_in;
    logic                   out_valid;
    logic                   out_ready;
    logic [EXP_W+MAN_W-1:0] float_out;
    logic [SIDE_W-1:0]      side_out;
    logic                   flag_zero;
    logic                   flag_uflow;

    modport slave (
        input  in_valid, m_sub, side_in, out_ready,
        output in_ready, out_valid, float_out, side_out,
        output flag_zero, flag_uflow
    );

    modport master (
        output in_valid, m_sub, side_in, out_ready,
        input  in_ready, out_valid, float_out, side_out,
        input  flag_zero, flag_uflow
    );

endinterface

// File: rtl/fp_norm_round_pipe_lzc.sv
// Combinational leading-zero counter for normalising stages.
// Ports: din in; cnt = leading zeros (W when all zero); zero = din==0.
module lzc_count
    import fp_pipe_pkg::*;
#(
    parameter int W  = 27,
    parameter int CW = clog2(W + 1)
) (
    input  logic [W-1:0]  din,
    output logic [CW-1:0] cnt,
    output logic          zero
);

    // Scan upward so the highest set bit wins.
    always_comb begin
        cnt = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (din[i])
                cnt = CW'(W - 1 - i);
        end
    end

    assign zero = (din == '0);

endmodule

// File: rtl/fp_norm_round_pipe.sv
// Two-stage normalise (lzc shift) then round/pack pipe with sideband.
// Ports: clk, rst_n (sync, active-low), bus = valid/ready data bundle.
module fp_norm_round_pipe
    import fp_pipe_pkg::*;
#(
    parameter int MAN_W    = 23,
    parameter int EXP_W    = 8,
    parameter int RND_W    = 3,
    parameter int BIAS     = 127,
    parameter int SIDE_W   = 31,
    parameter int RND_MODE = 1
) (
    input  logic clk,
    input  logic rst_n,
    fp_norm_round_pipe_if.slave bus
);

    localparam int W   = in_width(MAN_W, RND_W);
    localparam int CW  = clog2(W + 1);
    localparam int EW2 = EXP_W + 2;

    localparam logic [RND_W-1:0] GMASK    = (RND_W)'(1) << (RND_W - 1);
    localparam logic [RND_W-1:0] STK_MASK = ~GMASK;

    logic adv;
    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;

    // Stage 1: normalise
    logic [CW-1:0]         lzc;
    logic                  lz_zero;
    logic [W-2:0]          norm_lo;
    logic signed [EW2-1:0] exp_pre;

    lzc_count #(.W(W), .CW(CW)) u_lzc (
        .din  (bus.m_sub),
        .cnt  (lzc),
        .zero (lz_zero)
    );

    // The implicit bit is dropped; zero is tracked separately.
    assign norm_lo = (W-1)'(bus.m_sub << lzc);
    assign exp_pre = EW2'(BIAS) - EW2'(lzc);

    logic                  s1_valid;
    logic [W-2:0]          s1_norm;
    logic signed [EW2-1:0] s1_exp;
    logic                  s1_zero;
    logic [SIDE_W-1:0]     s1_side;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_norm  <= '0;
            s1_exp   <= '0;
            s1_zero  <= 1'b0;
            s1_side  <= '0;
        end else if (adv) begin
            s1_valid <= bus.in_valid;
            s1_norm  <= norm_lo;
            s1_exp   <= exp_pre;
            s1_zero  <= lz_zero;
            s1_side  <= bus.side_in;
        end
    end

    // Stage 2: round and pack
    logic [MAN_W-1:0]      mant;
    logic [MAN_W-1:0]      mant_r;
    logic                  guard;
    logic                  sticky;
    logic                  inc;
    logic                  carry;
    logic signed [EW2-1:0] exp_r;
    logic                  uflow;

    assign mant   = s1_norm[W-2 -: MAN_W];
    assign guard  = s1_norm[RND_W-1];
    assign sticky = |(s1_norm[RND_W-1:0] & STK_MASK);

    always_comb begin
        if (RND_MODE == RND_HALF_UP)
            inc = guard;
        else
            inc = guard && (sticky || mant[0]);
    end

    // All-ones mantissa + 1 wraps to zero; carry bumps the exponent.
    assign {carry, mant_r} = {1'b0, mant} + {{MAN_W{1'b0}}, inc};
    assign exp_r = s1_exp + {{(EW2-1){1'b0}}, carry};
    assign uflow = exp_r[EW2-1] || (exp_r == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.out_valid  <= 1'b0;
            bus.float_out  <= '0;
            bus.side_out   <= '0;
            bus.flag_zero  <= 1'b0;
            bus.flag_uflow <= 1'b0;
        end else if (adv) begin
            bus.out_valid  <= s1_valid;
            bus.side_out   <= s1_side;
            bus.flag_zero  <= s1_zero;
            bus.flag_uflow <= !s1_zero && uflow;
            if (s1_zero || uflow)
                bus.float_out <= '0;
            else
                bus.float_out <= {exp_r[EXP_W-1:0], mant_r};
        end
    end

endmodule

// File: tb/tb_fp_norm_round_pipe.sv
// Directed bench for fp_norm_round_pipe: RNE, half-up and small-bias copies.
// Vector table plus backpressure and mid-flight reset sequences.
module tb_fp_norm_round_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [26:0] m_sub;
    logic [30:0] side_in;

    always #5 clk = ~clk;

    fp_norm_round_pipe_if #(.MAN_W(23), .EXP_W(8), .RND_W(3), .SIDE_W(31)) ifa ();
    fp_norm_round_pipe_if #(.MAN_W(23), .EXP_W(8), .RND_W(3), .SIDE_W(31)) ifb ();
    fp_norm_round_pipe_if #(.MAN_W(23), .EXP_W(4), .RND_W(3), .SIDE_W(31)) ifc ();

    assign ifa.in_valid = in_valid;
    assign ifa.m_sub = m_sub;
    assign ifa.side_in = side_in;
    assign ifa.out_ready = out_ready;
    assign ifb.in_valid = in_valid;
    assign ifb.m_sub = m_sub;
    assign ifb.side_in = side_in;
    assign ifb.out_ready = out_ready;
    assign ifc.in_valid = in_valid;
    assign ifc.m_sub = m_sub;
    assign ifc.side_in = side_in;
    assign ifc.out_ready = out_ready;

    fp_norm_round_pipe #(
        .MAN_W(23), .EXP_W(8), .RND_W(3), .BIAS(127), .SIDE_W(31), .RND_MODE(1)
    ) dut_rne (.clk(clk), .rst_n(rst_n), .bus(ifa));

    fp_norm_round_pipe #(
        .MAN_W(23), .EXP_W(8), .RND_W(3), .BIAS(127), .SIDE_W(31), .RND_MODE(0)
    ) dut_hu (.clk(clk), .rst_n(rst_n), .bus(ifb));

    fp_norm_round_pipe #(
        .MAN_W(23), .EXP_W(4), .RND_W(3), .BIAS(3), .SIDE_W(31), .RND_MODE(1)
    ) dut_small (.clk(clk), .rst_n(rst_n), .bus(ifc));

    typedef struct {
        logic [26:0] m;
        logic [30:0] side;
        logic [30:0] f_rne;
        logic [30:0] f_hu;
        logic        z;
    } vec_t;

    vec_t vecs [9];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [30:0] exp_f [$];
    logic [30:0] exp_s [$];
    int          sent;
    int          got;
    logic        prev_stall;
    logic        saw_block;
    logic [30:0] held_f;
    logic [30:0] held_s;

    initial begin
        vecs[0] = '{27'h4000000, 31'h1234, 31'h3F800000, 31'h3F800000, 1'b0};
        vecs[1] = '{27'h2000000, 31'h0055, 31'h3F000000, 31'h3F000000, 1'b0};
        vecs[2] = '{27'h0000001, 31'h0ABC, 31'h32800000, 31'h32800000, 1'b0};
        vecs[3] = '{27'h4000004, 31'h0001, 31'h3F800000, 31'h3F800001, 1'b0};
        vecs[4] = '{27'h400000C, 31'h0002, 31'h3F800002, 31'h3F800002, 1'b0};
        vecs[5] = '{27'h7FFFFFC, 31'h0003, 31'h40000000, 31'h40000000, 1'b0};
        vecs[6] = '{27'h0000000, 31'h0004, 31'h00000000, 31'h00000000, 1'b1};
        vecs[7] = '{27'h4000006, 31'h0005, 31'h3F800001, 31'h3F800001, 1'b0};
        vecs[8] = '{27'h0000003, 31'h0006, 31'h33400000, 31'h33400000, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        m_sub     = '0;
        side_in   = '0;
        tick();
        tick();
        chk("rst_out_valid", 64'(ifa.out_valid), 64'd0);
        chk("rst_float", 64'(ifa.float_out), 64'd0);
        chk("rst_side", 64'(ifa.side_out), 64'd0);
        chk("rst_flags", 64'({ifa.flag_zero, ifa.flag_uflow}), 64'd0);
        chk("rst_in_ready", 64'(ifa.in_ready), 64'd1);
        rst_n = 1'b1;
        tick();

        // Single words through the empty pipe.
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            m_sub    = vecs[i].m;
            side_in  = vecs[i].side;
            tick();
            in_valid = 1'b0;
            chk($sformatf("v%0d_lat1", i), 64'(ifa.out_valid), 64'd0);
            tick();
            chk($sformatf("v%0d_valid", i), 64'(ifa.out_valid), 64'd1);
            chk($sformatf("v%0d_rne", i), 64'(ifa.float_out),
                64'(vecs[i].f_rne));
            chk($sformatf("v%0d_hu", i), 64'(ifb.float_out),
                64'(vecs[i].f_hu));
            chk($sformatf("v%0d_side", i), 64'(ifa.side_out),
                64'(vecs[i].side));
            chk($sformatf("v%0d_zero", i), 64'(ifa.flag_zero),
                64'(vecs[i].z));
            chk($sformatf("v%0d_uflow", i), 64'(ifa.flag_uflow), 64'd0);
        end
        tick();

        // Backpressure: 5 words streamed, out_ready low for cycles 2..5.
        sent       = 0;
        got        = 0;
        prev_stall = 1'b0;
        saw_block  = 1'b0;
        for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
            in_valid  = (sent < 5);
            m_sub     = vecs[sent < 5 ? sent : 0].m;
            side_in   = vecs[sent < 5 ? sent : 0].side;
            out_ready = !(cyc >= 2 && cyc < 6);
            @(negedge clk);
            if (prev_stall) begin
                chk("bp_hold_float", 64'(ifa.float_out), 64'(held_f));
                chk("bp_hold_side", 64'(ifa.side_out), 64'(held_s));
            end
            if (in_valid && !ifa.in_ready)
                saw_block = 1'b1;
            if (in_valid && ifa.in_ready) begin
                exp_f.push_back(vecs[sent].f_rne);
                exp_s.push_back(vecs[sent].side);
                sent++;
            end
            if (ifa.out_valid && out_ready) begin
                if (exp_f.size() == 0) begin
                    chk("bp_extra_word", 64'd1, 64'd0);
                end else begin
                    chk("bp_float", 64'(ifa.float_out), 64'(exp_f.pop_front()));
                    chk("bp_side", 64'(ifa.side_out), 64'(exp_s.pop_front()));
                end
                got++;
            end
            prev_stall = ifa.out_valid && !out_ready;
            held_f     = ifa.float_out;
            held_s     = ifa.side_out;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_count", 64'(got), 64'd5);
        chk("bp_sent", 64'(sent), 64'd5);
        chk("bp_blocked", 64'(saw_block), 64'd1);
        tick();
        tick();
        chk("bp_drained", 64'(ifa.out_valid), 64'd0);

        // Reset with two words in flight.
        in_valid = 1'b1;
        m_sub    = vecs[0].m;
        side_in  = vecs[0].side;
        tick();
        m_sub    = vecs[1].m;
        side_in  = vecs[1].side;
        tick();
        chk("pre_rst_valid", 64'(ifa.out_valid), 64'd1);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        chk("mid_rst_valid", 64'(ifa.out_valid), 64'd0);
        chk("mid_rst_float", 64'(ifa.float_out), 64'd0);
        chk("mid_rst_side", 64'(ifa.side_out), 64'd0);
        chk("mid_rst_flags", 64'({ifa.flag_zero, ifa.flag_uflow}), 64'd0);
        rst_n    = 1'b1;
        in_valid = 1'b1;
        m_sub    = 27'h0000001;
        side_in  = 31'h0777;
        tick();
        in_valid = 1'b0;
        chk("post_rst_no_ghost", 64'(ifa.out_valid), 64'd0);
        tick();
        chk("post_rst_valid", 64'(ifa.out_valid), 64'd1);
        chk("post_rst_float", 64'(ifa.float_out), 64'h32800000);
        chk("post_rst_side", 64'(ifa.side_out), 64'h0777);
        chk("small_valid", 64'(ifc.out_valid), 64'd1);
        chk("small_uflow", 64'(ifc.flag_uflow), 64'd1);
        chk("small_float", 64'(ifc.float_out), 64'd0);
        chk("small_zero", 64'(ifc.flag_zero), 64'd0);
        tick();
        chk("post_rst_empty", 64'(ifa.out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
